intersection_controller: RTL and testbench
==========================================

// Module: intersection_controller
// PURPOSE
//  Sequences one two-road intersection: drives the North-South and East-West 4-bit light vectors
//  ({left, green, yellow, red}) from a single phase FSM so conflicting greens are impossible.
//  Adds an all-red clearance phase, a pedestrian walk phase on request, and directional emergency
//  preemption. Sits above the per-direction lamp drivers and replaces free-running per-direction lights.
// PARAMETERS
//  LEFT_T    5   cycles of protected left (left + red) per direction
//  GREEN_T   10  cycles of green per direction
//  YELLOW_T  3   cycles of yellow per direction
//  CLEAR_T   1   cycles of all-red clearance after each yellow
//  WALK_T    8   cycles of pedestrian walk (all vehicle lights red)
//  CW        5   phase counter width; every *_T must be in 1..2^CW-1
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  emergency  in   1  level: emergency vehicle present, sampled every cycle
//  emg_dir    in   1  requested emergency direction, 0=NS 1=EW; captured when preemption starts
//  ped_req    in   1  pedestrian button; any high cycle sets an internal pending flag
//  ns_out     out  4  NS lights {left,green,yellow,red}
//  ew_out     out  4  EW lights {left,green,yellow,red}
//  walk       out  1  pedestrian walk lamp
//  phase      out  4  current FSM state code (debug/observability)
// BEHAVIOUR
//  - States (code): NS_LEFT 0, NS_GREEN 1, NS_YELLOW 2, CLEAR_A 3, EW_LEFT 4, EW_GREEN 5,
//    EW_YELLOW 6, CLEAR_B 7, PED_WALK 8, EMG_YELLOW 9, EMG_CLEAR 10, EMG_HOLD 11.
//  - Outputs are pure decode of the state register, valid in the same cycle the state is entered.
//    Active direction: LEFT=1001, GREEN=0100, YELLOW=0010. Other direction and all CLEAR/WALK: 0001.
//  - walk=1 only in PED_WALK.
//  - Reset: state NS_LEFT, counter 0, ped_pending 0, emg_dir_q 0 -> ns_out=1001, ew_out=0001, walk=0.
//    Reset wins over every other input, including mid-preemption.
//  - Dwell: counter runs 0..T-1, then the FSM advances and the counter returns to 0. Each state lasts
//    exactly T cycles.
//  - Normal order: NS_LEFT > NS_GREEN > NS_YELLOW > CLEAR_A > EW_LEFT > EW_GREEN > EW_YELLOW > CLEAR_B
//    > (ped_pending ? PED_WALK : NS_LEFT). PED_WALK exits to NS_LEFT.
//  - ped_pending: set by ped_req in any state except PED_WALK (ignored there). Cleared on the entry
//    edge into PED_WALK; clear wins over a same-cycle ped_req.
//  - Preemption: triggered when emergency=1 in any non-EMG state; emg_dir_q<=emg_dir on that edge.
//    * Current state is LEFT/GREEN of emg_dir: go to EMG_HOLD, counter 0.
//    * Current state is LEFT/GREEN of the other direction: go to EMG_YELLOW (yellow on that
//      direction), counter 0.
//    * Current state is YELLOW of either direction: go to EMG_YELLOW and keep the counter
//      (remaining yellow is honoured).
//    * Current state is CLEAR_A, CLEAR_B or PED_WALK: go to EMG_CLEAR, counter 0. An aborted walk
//      re-sets ped_pending.
//    * EMG_YELLOW lasts YELLOW_T, then EMG_CLEAR. EMG_CLEAR lasts CLEAR_T, then EMG_HOLD.
//      The sequence runs to completion even if emergency drops.
//    * EMG_HOLD: emg_dir_q direction=0100, other=0001. Held while emergency=1, minimum 1 cycle.
//      emg_dir changes are ignored until the hold exits.
//    * First cycle with emergency=0 in EMG_HOLD: go to the emg_dir_q YELLOW state, counter 0,
//      then resume the normal order.
//  - Invariant: at most one of ns_out/ew_out has bit[3] or bit[2] set. Yellow is never followed
//    directly by the other direction's green or left.
// TESTING
//  1. Reset, then free-run with no requests: NS 1001x5, 0100x10, 0010x3, both 0001x1; EW mirrors.
//     Period is 38 cycles and phase returns to 0 at cycle 38.
//  2. ped_req 1-cycle pulse during NS_GREEN: after CLEAR_B, PED_WALK for 8 cycles with walk=1 and
//     both outputs 0001, then NS_LEFT. Period is 46. The next period is 38 again.
//  3. emergency=1, emg_dir=1 at NS_GREEN counter 3: ns 0010 for 3 cycles, then both 0001 for 1
//     cycle, then ew 0100 held. Drop emergency: EW_YELLOW x3, CLEAR_B, NS_LEFT.
//  4. emergency=1, emg_dir=0 during NS_LEFT: next cycle phase=11 and ns 0100. Toggle emg_dir while
//     held: no change.
//  5. emergency=1 during PED_WALK counter 4: walk=0 next cycle, EMG_CLEAR, ped_pending set, and the
//     walk is served in full after the next CLEAR_B.
//  6. reset=1 during EMG_YELLOW with ped_pending set: next edge phase=0, ns 1001, ew 0001, walk 0,
//     and no walk phase in the following cycle.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: one phase FSM drives the NS/EW light vectors, an all-red
// clearance, an on-request pedestrian walk, and directional emergency preemption.
module intersection_controller #(
    parameter int unsigned LEFT_T   = 5,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned CLEAR_T  = 1,
    parameter int unsigned WALK_T   = 8,
    parameter int unsigned CW       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    input  logic       emg_dir,
    input  logic       ped_req,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic       walk,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        NS_LEFT    = 4'd0,
        NS_GREEN   = 4'd1,
        NS_YELLOW  = 4'd2,
        CLEAR_A    = 4'd3,
        EW_LEFT    = 4'd4,
        EW_GREEN   = 4'd5,
        EW_YELLOW  = 4'd6,
        CLEAR_B    = 4'd7,
        PED_WALK   = 4'd8,
        EMG_YELLOW = 4'd9,
        EMG_CLEAR  = 4'd10,
        EMG_HOLD   = 4'd11
    } state_t;

    localparam logic [3:0] LT_LEFT  = 4'b1001;
    localparam logic [3:0] LT_GREEN = 4'b0100;
    localparam logic [3:0] LT_YEL   = 4'b0010;
    localparam logic [3:0] LT_RED   = 4'b0001;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_ped_pending, w_ped_nxt;
    logic            r_emg_dir_q, w_emg_dir_nxt;
    logic            r_yel_ew, w_yel_ew_nxt;
    logic [3:0]      r_ns_out, r_ew_out;
    logic            r_walk;
    logic            w_last;
    logic            w_in_emg;
    logic [8:0]      w_lamps_nxt;

    // Final counter value of each timed state; EMG_HOLD is untimed.
    function automatic logic [CW-1:0] dwell_last(input state_t s);
        case (s)
            NS_LEFT, EW_LEFT:                dwell_last = CW'(LEFT_T - 1);
            NS_GREEN, EW_GREEN:              dwell_last = CW'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW, EMG_YELLOW: dwell_last = CW'(YELLOW_T - 1);
            CLEAR_A, CLEAR_B, EMG_CLEAR:     dwell_last = CW'(CLEAR_T - 1);
            PED_WALK:                        dwell_last = CW'(WALK_T - 1);
            default:                         dwell_last = CW'(0);
        endcase
    endfunction

    // Lamp decode {ns, ew, walk}; unlisted directions stay red.
    function automatic logic [8:0] decode(input state_t s, input logic dir_ew, input logic yel_ew);
        logic [3:0] ns;
        logic [3:0] ew;
        logic       wk;
        ns = LT_RED;
        ew = LT_RED;
        wk = 1'b0;
        case (s)
            NS_LEFT:    ns = LT_LEFT;
            NS_GREEN:   ns = LT_GREEN;
            NS_YELLOW:  ns = LT_YEL;
            EW_LEFT:    ew = LT_LEFT;
            EW_GREEN:   ew = LT_GREEN;
            EW_YELLOW:  ew = LT_YEL;
            PED_WALK:   wk = 1'b1;
            EMG_YELLOW: if (yel_ew) ew = LT_YEL;   else ns = LT_YEL;
            EMG_HOLD:   if (dir_ew) ew = LT_GREEN; else ns = LT_GREEN;
            default:    ;
        endcase
        decode = {ns, ew, wk};
    endfunction

    assign w_last   = (r_cnt == dwell_last(r_state));
    assign w_in_emg = (r_state == EMG_YELLOW) || (r_state == EMG_CLEAR) || (r_state == EMG_HOLD);

    // Next-state, counter and side-register logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CW'(1);
        w_ped_nxt     = r_ped_pending | (ped_req & (r_state != PED_WALK));
        w_emg_dir_nxt = r_emg_dir_q;
        w_yel_ew_nxt  = r_yel_ew;

        if (emergency && !w_in_emg) begin
            w_emg_dir_nxt = emg_dir;
            w_cnt_nxt     = '0;
            case (r_state)
                NS_LEFT, NS_GREEN: begin
                    if (!emg_dir) w_state_nxt = EMG_HOLD;
                    else begin
                        w_state_nxt  = EMG_YELLOW;
                        w_yel_ew_nxt = 1'b0;
                    end
                end
                EW_LEFT, EW_GREEN: begin
                    if (emg_dir) w_state_nxt = EMG_HOLD;
                    else begin
                        w_state_nxt  = EMG_YELLOW;
                        w_yel_ew_nxt = 1'b1;
                    end
                end
                NS_YELLOW, EW_YELLOW: begin
                    // Remaining yellow time is honoured by keeping the count.
                    w_state_nxt  = EMG_YELLOW;
                    w_yel_ew_nxt = (r_state == EW_YELLOW);
                    w_cnt_nxt    = r_cnt;
                end
                PED_WALK: begin
                    w_state_nxt = EMG_CLEAR;
                    w_ped_nxt   = 1'b1;
                end
                default: w_state_nxt = EMG_CLEAR;
            endcase
        end else if (r_state == EMG_HOLD) begin
            w_cnt_nxt = '0;
            if (!emergency) w_state_nxt = r_emg_dir_q ? EW_YELLOW : NS_YELLOW;
        end else if (w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
                NS_LEFT:    w_state_nxt = NS_GREEN;
                NS_GREEN:   w_state_nxt = NS_YELLOW;
                NS_YELLOW:  w_state_nxt = CLEAR_A;
                CLEAR_A:    w_state_nxt = EW_LEFT;
                EW_LEFT:    w_state_nxt = EW_GREEN;
                EW_GREEN:   w_state_nxt = EW_YELLOW;
                EW_YELLOW:  w_state_nxt = CLEAR_B;
                CLEAR_B:    w_state_nxt = r_ped_pending ? PED_WALK : NS_LEFT;
                EMG_YELLOW: w_state_nxt = EMG_CLEAR;
                EMG_CLEAR:  w_state_nxt = EMG_HOLD;
                default:    w_state_nxt = NS_LEFT;
            endcase
        end

        if ((w_state_nxt == PED_WALK) && (r_state != PED_WALK)) w_ped_nxt = 1'b0;
    end

    assign w_lamps_nxt = decode(w_state_nxt, w_emg_dir_nxt, w_yel_ew_nxt);

    // State and lamp registers; lamps are decoded from the next state so they track the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= NS_LEFT;
            r_cnt         <= '0;
            r_ped_pending <= 1'b0;
            r_emg_dir_q   <= 1'b0;
            r_yel_ew      <= 1'b0;
            r_ns_out      <= LT_LEFT;
            r_ew_out      <= LT_RED;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ped_pending <= w_ped_nxt;
            r_emg_dir_q   <= w_emg_dir_nxt;
            r_yel_ew      <= w_yel_ew_nxt;
            r_ns_out      <= w_lamps_nxt[8:5];
            r_ew_out      <= w_lamps_nxt[4:1];
            r_walk        <= w_lamps_nxt[0];
        end
    end

    assign ns_out = r_ns_out;
    assign ew_out = r_ew_out;
    assign walk   = r_walk;
    assign phase  = r_state;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: free-run timing, pedestrian walk, emergency
// preemption from several phases, and reset during preemption.
module tb_intersection_controller;

    localparam logic [3:0] L = 4'b1001;
    localparam logic [3:0] G = 4'b0100;
    localparam logic [3:0] Y = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic       clk;
    logic       reset;
    logic       emergency;
    logic       emg_dir;
    logic       ped_req;
    logic [3:0] ns_out;
    logic [3:0] ew_out;
    logic       walk;
    logic [3:0] phase;

    int n_vec;
    int n_err;

    intersection_controller dut (
        .clk       (clk),
        .reset     (reset),
        .emergency (emergency),
        .emg_dir   (emg_dir),
        .ped_req   (ped_req),
        .ns_out    (ns_out),
        .ew_out    (ew_out),
        .walk      (walk),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {phase, ns, ew, walk} against the hand-computed value.
    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got ph=%0d ns=%b ew=%b walk=%b, want ph=%0d ns=%b ew=%b walk=%b",
                     tag, got[12:9], got[8:5], got[4:1], got[0],
                     exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect the same lamp pattern for n consecutive cycles.
    task automatic run(input string tag, input int n, input logic [3:0] ph,
                       input logic [3:0] ns, input logic [3:0] ew, input logic wk);
        for (int i = 0; i < n; i++) begin
            check(tag, {phase, ns_out, ew_out, walk}, {ph, ns, ew, wk});
            step();
        end
    endtask

    task automatic ew_half(input string tag);
        run({tag, ":ew_left"},  5,  4'd4, R, L, 1'b0);
        run({tag, ":ew_green"}, 10, 4'd5, R, G, 1'b0);
        run({tag, ":ew_yel"},   3,  4'd6, R, Y, 1'b0);
        run({tag, ":clear_b"},  1,  4'd7, R, R, 1'b0);
    endtask

    task automatic full_cycle(input string tag);
        run({tag, ":ns_left"},  5,  4'd0, L, R, 1'b0);
        run({tag, ":ns_green"}, 10, 4'd1, G, R, 1'b0);
        run({tag, ":ns_yel"},   3,  4'd2, Y, R, 1'b0);
        run({tag, ":clear_a"},  1,  4'd3, R, R, 1'b0);
        ew_half(tag);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        emergency = 1'b0;
        emg_dir   = 1'b0;
        ped_req   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // 1: free run, 38-cycle period
        full_cycle("t1a");
        full_cycle("t1b");

        // 2: pedestrian request in NS_GREEN adds an 8-cycle walk
        run("t2:ns_left", 5, 4'd0, L, R, 1'b0);
        ped_req = 1'b1;
        run("t2:ns_green_req", 1, 4'd1, G, R, 1'b0);
        ped_req = 1'b0;
        run("t2:ns_green", 9, 4'd1, G, R, 1'b0);
        run("t2:ns_yel",   3, 4'd2, Y, R, 1'b0);
        run("t2:clear_a",  1, 4'd3, R, R, 1'b0);
        ew_half("t2");
        run("t2:walk",     8, 4'd8, R, R, 1'b1);
        full_cycle("t2n");

        // 3: EW emergency at NS_GREEN count 3
        run("t3:ns_left",  5, 4'd0, L, R, 1'b0);
        run("t3:ns_green", 3, 4'd1, G, R, 1'b0);
        emergency = 1'b1;
        emg_dir   = 1'b1;
        run("t3:trigger",  1, 4'd1, G, R, 1'b0);
        run("t3:emg_yel",  3, 4'd9, Y, R, 1'b0);
        run("t3:emg_clr",  1, 4'd10, R, R, 1'b0);
        run("t3:hold",     4, 4'd11, R, G, 1'b0);
        emergency = 1'b0;
        run("t3:hold_end", 1, 4'd11, R, G, 1'b0);
        run("t3:ew_yel",   3, 4'd6, R, Y, 1'b0);
        run("t3:clear_b",  1, 4'd7, R, R, 1'b0);

        // 4: NS emergency in NS_LEFT goes straight to hold; emg_dir toggles ignored
        emergency = 1'b1;
        emg_dir   = 1'b0;
        run("t4:trigger",  1, 4'd0, L, R, 1'b0);
        run("t4:hold",     2, 4'd11, G, R, 1'b0);
        emg_dir = 1'b1;
        run("t4:hold_tog", 3, 4'd11, G, R, 1'b0);
        emg_dir   = 1'b0;
        emergency = 1'b0;
        run("t4:hold_end", 1, 4'd11, G, R, 1'b0);
        run("t4:ns_yel",   3, 4'd2, Y, R, 1'b0);
        run("t4:clear_a",  1, 4'd3, R, R, 1'b0);
        ew_half("t4");

        // 5: emergency aborts a walk; walk is re-served in full
        ped_req = 1'b1;
        run("t5:ns_left_req", 1, 4'd0, L, R, 1'b0);
        ped_req = 1'b0;
        run("t5:ns_left",  4, 4'd0, L, R, 1'b0);
        run("t5:ns_green", 10, 4'd1, G, R, 1'b0);
        run("t5:ns_yel",   3, 4'd2, Y, R, 1'b0);
        run("t5:clear_a",  1, 4'd3, R, R, 1'b0);
        ew_half("t5");
        run("t5:walk",     4, 4'd8, R, R, 1'b1);
        emergency = 1'b1;
        run("t5:walk_trig", 1, 4'd8, R, R, 1'b1);
        emergency = 1'b0;
        run("t5:emg_clr",  1, 4'd10, R, R, 1'b0);
        run("t5:hold",     1, 4'd11, G, R, 1'b0);
        run("t5:ns_yel",   3, 4'd2, Y, R, 1'b0);
        run("t5:clear_a",  1, 4'd3, R, R, 1'b0);
        ew_half("t5");
        run("t5:walk_full", 8, 4'd8, R, R, 1'b1);

        // 6: reset during EMG_YELLOW with a pending walk
        ped_req = 1'b1;
        run("t6:ns_left_req", 1, 4'd0, L, R, 1'b0);
        ped_req   = 1'b0;
        emergency = 1'b1;
        emg_dir   = 1'b1;
        run("t6:trigger",  1, 4'd0, L, R, 1'b0);
        emergency = 1'b0;
        run("t6:emg_yel",  1, 4'd9, Y, R, 1'b0);
        reset = 1'b1;
        run("t6:emg_yel_rst", 1, 4'd9, Y, R, 1'b0);
        reset   = 1'b0;
        emg_dir = 1'b0;
        full_cycle("t6");
        run("t6:no_walk",  1, 4'd0, L, R, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
